// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control blocks: controller states,
// the hard-wired zero register index and the NOP used by bubble muxes.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        MDU_BUSY    = 2'd1,
        MDU_RELEASE = 2'd2
    } state_t;

    localparam logic [4:0]  REG_ZERO  = 5'b00000;

    // sll $0,$0,0 -- the canonical all-zero NOP loaded by bubble muxes
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // count up on inc, hold at all-ones, clear on demand
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage core: load-use interlock,
// taken-branch wrong-path squash and multi-cycle MDU occupancy of EX.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// RUN         | normal flow; branch, MDU start and load-use are resolved
// MDU_BUSY    | MDU holds EX; front end frozen, EX/MEM fed bubbles
// MDU_RELEASE | MDU instruction advances; same ID/EX op must not re-trigger
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IFID_Rs,
    input  logic [4:0]       IFID_Rt,
    input  logic [4:0]       IDEX_Rt,
    input  logic             IDEX_MemRead,
    input  logic             branch_taken,
    input  logic             mdu_start,
    input  logic             stall_clr,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int              CW       = $clog2(MDU_LAT);
    // start cycle plus the cnt==0 cycle account for two of the MDU_LAT
    localparam logic [CW-1:0]   CNT_LOAD = CW'(MDU_LAT - 2);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          load_use;

    assign load_use = IDEX_MemRead && (IDEX_Rt != REG_ZERO) &&
                      ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));

    // state and MDU occupancy counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // next state, counter and pipeline control; pass-through unless overridden
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        mdu_busy     = 1'b0;

        case (state)
            RUN: begin
                if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (mdu_start) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_bubble = 1'b1;
                    mdu_busy     = 1'b1;
                    cnt_nxt      = CNT_LOAD;
                    state_nxt    = MDU_BUSY;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            MDU_BUSY: begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_bubble = 1'b1;
                mdu_busy     = 1'b1;
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    state_nxt = MDU_RELEASE;
                end
            end
            MDU_RELEASE: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase

        // hold pass-through values while reset is asserted
        if (!rst_n) begin
            pc_write     = 1'b1;
            ifid_write   = 1'b1;
            idex_write   = 1'b1;
            ifid_flush   = 1'b0;
            idex_bubble  = 1'b0;
            exmem_bubble = 1'b0;
            mdu_busy     = 1'b0;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stall_clr),
        .inc   (!pc_write),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (MDU_LAT=4, CNT_W=4).
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] IFID_Rs, IFID_Rt, IDEX_Rt;
    logic       IDEX_MemRead, branch_taken, mdu_start, stall_clr;
    logic       pc_write, ifid_write, ifid_flush, idex_write;
    logic       idex_bubble, exmem_bubble, mdu_busy;
    logic [3:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    hazard_stall_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .IFID_Rs      (IFID_Rs),
        .IFID_Rt      (IFID_Rt),
        .IDEX_Rt      (IDEX_Rt),
        .IDEX_MemRead (IDEX_MemRead),
        .branch_taken (branch_taken),
        .mdu_start    (mdu_start),
        .stall_clr    (stall_clr),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_write   (idex_write),
        .idex_bubble  (idex_bubble),
        .exmem_bubble (exmem_bubble),
        .mdu_busy     (mdu_busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // pc_write,ifid_write,idex_write,ifid_flush,idex_bubble,exmem_bubble,mdu_busy
    task automatic check_ctl(input string tag, input logic [6:0] exp);
        check(tag, {25'd0, pc_write, ifid_write, idex_write, ifid_flush,
                    idex_bubble, exmem_bubble, mdu_busy}, {25'd0, exp});
    endtask

    localparam logic [6:0] PASS  = 7'b111_0000;
    localparam logic [6:0] LUSE  = 7'b001_0100;
    localparam logic [6:0] BRN   = 7'b111_1100;
    localparam logic [6:0] MDU   = 7'b000_0011;

    task automatic idle_inputs();
        IFID_Rs = 5'd0; IFID_Rt = 5'd0; IDEX_Rt = 5'd0;
        IDEX_MemRead = 1'b0; branch_taken = 1'b0; mdu_start = 1'b0; stall_clr = 1'b0;
    endtask

    // advance to the next negedge (inputs change there; posedge is mid-way)
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_ctl("ctl_in_reset", PASS);
        check("cnt_in_reset", stall_cycles, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check_ctl("ctl_after_reset", PASS);
        check("cnt_after_reset", stall_cycles, 0);

        // load-use via rs
        next_cycle();
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd5; IFID_Rs = 5'd5;
        #2 check_ctl("luse_rs", LUSE);
        @(posedge clk); #1 check("luse_rs_cnt", stall_cycles, 1);

        // load to $zero never stalls
        next_cycle();
        IDEX_Rt = 5'd0; IFID_Rs = 5'd0; IFID_Rt = 5'd0;
        #2 check_ctl("luse_zero", PASS);
        @(posedge clk); #1 check("luse_zero_cnt", stall_cycles, 1);

        // match but not a load
        next_cycle();
        IDEX_MemRead = 1'b0; IDEX_Rt = 5'd9; IFID_Rt = 5'd9;
        #2 check_ctl("no_load", PASS);

        // branch outranks load-use and mdu_start
        next_cycle();
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd7; IFID_Rt = 5'd7;
        branch_taken = 1'b1; mdu_start = 1'b1;
        #2 check_ctl("branch_prio", BRN);
        @(posedge clk); #1 check("branch_cnt", stall_cycles, 1);
        next_cycle();
        idle_inputs();
        #2 check_ctl("after_branch", PASS);

        // MDU: mdu_start held high, 4 stalled cycles then one pass-through
        next_cycle();
        mdu_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                branch_taken = 1'b1;
                IDEX_MemRead = 1'b1; IDEX_Rt = 5'd3; IFID_Rs = 5'd3;
            end
            #2 check_ctl($sformatf("mdu_busy_%0d", i), MDU);
            next_cycle();
            branch_taken = 1'b0; IDEX_MemRead = 1'b0;
        end
        #2 check_ctl("mdu_release", PASS);
        check("mdu_cnt", stall_cycles, 5);
        next_cycle();
        mdu_start = 1'b0;
        #2 check_ctl("after_release", PASS);
        check("after_release_cnt", stall_cycles, 5);

        // reset in the 2nd busy cycle
        next_cycle();
        mdu_start = 1'b1;
        next_cycle();
        mdu_start = 1'b0;
        #2 check_ctl("mdu_2nd_busy", MDU);
        rst_n = 1'b0;
        #1 check_ctl("mid_reset_ctl", PASS);
        check("mid_reset_cnt", stall_cycles, 0);
        next_cycle();
        rst_n = 1'b1;
        #2 check_ctl("post_reset_ctl", PASS);
        @(posedge clk); #1 check("post_reset_cnt", stall_cycles, 0);
        next_cycle();
        #2 check_ctl("no_release_stall", PASS);

        // saturation: 20 consecutive load-use stalls
        next_cycle();
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd12; IFID_Rt = 5'd12;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 14 || i == 15 || i == 20)
                check($sformatf("sat_%0d", i), stall_cycles, (i > 15) ? 15 : i);
        end

        // clear beats increment on a stall cycle
        next_cycle();
        stall_clr = 1'b1;
        #2 check_ctl("clr_stall_ctl", LUSE);
        @(posedge clk); #1 check("clr_cnt", stall_cycles, 0);
        next_cycle();
        stall_clr = 1'b0;
        @(posedge clk); #1 check("after_clr_cnt", stall_cycles, 1);

        next_cycle();
        idle_inputs();
        @(posedge clk); #1 check("idle_cnt", stall_cycles, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline stall/flush controller for the 5-stage core. It sits beside the forwarding unit and covers the hazards forwarding cannot resolve: load-use, taken-branch wrong-path, and multi-cycle multiply/divide (MDU) occupancy of EX. It drives the PC and pipeline-register write enables, flushes and bubbles. It also keeps a saturating stall-cycle performance counter.

Parameters:
MDU_LAT, 4, total EX occupancy of a mult/div instruction in cycles; legal values are 2..16.
CNT_W, 16, width of the stall-cycle performance counter.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset; asynchronous, active-low
IFID_Rs  input  5  rs of the instruction in IF/ID
IFID_Rt  input  5  rt of the instruction in IF/ID
IDEX_Rt  input  5  rt (load destination) of the instruction in ID/EX
IDEX_MemRead  input  1  ID/EX instruction is a load
branch_taken  input  1  branch/jump in EX resolved taken
mdu_start  input  1  ID/EX instruction is mult/div
stall_clr  input  1  synchronous clear of stall_cycles
pc_write  output  1  PC update enable
ifid_write  output  1  IF/ID load enable
ifid_flush  output  1  zero IF/ID contents
idex_write  output  1  ID/EX load enable
idex_bubble  output  1  load NOP into ID/EX
exmem_bubble  output  1  load NOP into EX/MEM
mdu_busy  output  1  high while the MDU holds EX
stall_cycles  output  CNT_W  count of cycles with pc_write=0

Behaviour:
- State register: RUN, MDU_BUSY, MDU_RELEASE. Down-counter cnt is $clog2(MDU_LAT) bits wide.
- Outputs are combinational from state and the current inputs.
- Default (pass-through) outputs: pc_write=1, ifid_write=1, idex_write=1, ifid_flush=0, idex_bubble=0, exmem_bubble=0, mdu_busy=0.
- Reset (rst_n=0, asynchronous): state=RUN, cnt=0, stall_cycles=0. Outputs take their RUN pass-through values while in reset.
- RUN priority order (first match wins):
  1. branch_taken: ifid_flush=1, idex_bubble=1, PC writes the target (pc_write=1). Any coincident mdu_start or load-use is ignored. Stay in RUN.
  2. mdu_start: pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1, mdu_busy=1. Load cnt=MDU_LAT-2. Next state MDU_BUSY.
  3. Load-use: detected when IDEX_MemRead=1, IDEX_Rt!=0, and IDEX_Rt equals IFID_Rs or IFID_Rt. Outputs: pc_write=0, ifid_write=0, idex_bubble=1. Stay in RUN. The hazard clears naturally the next cycle, giving exactly a 1-cycle stall.
  4. Otherwise pass-through.
- MDU_BUSY: same outputs as RUN case 2. branch_taken, mdu_start and load-use are ignored.
  - If cnt!=0: cnt decrements.
  - If cnt==0: next state MDU_RELEASE.
  - Total stalled cycles = MDU_LAT, counting the start cycle.
- MDU_RELEASE: pass-through outputs; the MDU instruction advances.
  - mdu_start is ignored to prevent re-trigger by the same instruction still in ID/EX.
  - Load-use and branch are also ignored; they are impossible here because ID/EX holds the MDU instruction.
  - Next state RUN.
- stall_cycles, per clock edge:
  - stall_clr=1: clears to 0. This has priority over increment.
  - Otherwise: increments when pc_write=0.
  - Saturates at all-ones; no wrap.
- Reset mid-MDU: immediate return to RUN with cnt=0. No release cycle is generated.
- Illegal state encoding: recover to RUN on the next edge.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state enum (RUN, MDU_BUSY, MDU_RELEASE);
  - the REG_ZERO constant (5'b00000);
  - the NOP instruction constant used by the bubble muxes in the pipeline registers.
- One sub-module: sat_counter (parameter W; ports clk, rst_n, clr, inc, count), instantiated for stall_cycles.
- The FSM, cnt and hazard compare stay in hazard_stall_ctrl.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> pc_write=1, ifid_write=1, idex_write=1, all flush/bubble=0, mdu_busy=0, stall_cycles=0.
- Load-use: IDEX_MemRead=1, IDEX_Rt=5, IFID_Rs=5 for one cycle -> that cycle pc_write=0, ifid_write=0, idex_bubble=1, and stall_cycles=1 after the edge. Repeat with IDEX_Rt=0 and IFID_Rt=0 -> no stall.
- Branch priority: branch_taken=1 together with a load-use match (IDEX_Rt=7, IFID_Rt=7) -> ifid_flush=1, idex_bubble=1, pc_write=1; stall_cycles unchanged.
- MDU, MDU_LAT=4: pulse mdu_start, then hold it high -> pc_write=0, idex_write=0, exmem_bubble=1, mdu_busy=1 for exactly 4 cycles. The 5th cycle is pass-through despite mdu_start=1. stall_cycles increases by 4.
- Reset mid-MDU: rst_n=0 in the 2nd busy cycle, then released with mdu_start=0 -> pc_write=1 immediately; state RUN; stall_cycles=0.
- Saturation, CNT_W=4: 20 consecutive load-use stall cycles -> stall_cycles holds at 15. Pulse stall_clr during a stall cycle -> 0 after the edge.
